hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI/LO registers. It feeds them to the ALU hi/lo inputs used by MFHI/MFLO.
- Executes MULT, MULTU, DIV and DIVU over 34 cycles, one bit per CALC cycle. Handles MTHI/MTLO writes.
- Asserts a stall to the pipeline while busy. Sits in EX beside the ALU.

Parameters:
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- CNT_W, 6, iteration counter width.
- DIV0_Q, 32'hFFFF_FFFF, quotient written to LO on divide-by-zero.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  in  32  rs operand: multiplicand or dividend.
- b  in  32  rt operand: multiplier or divisor.
- flush  in  1  abort any in-flight operation.
- mthi_we  in  1  write wdata to HI.
- mtlo_we  in  1  write wdata to LO.
- wdata  in  32  MTHI/MTLO data.
- stall  out  1  pipeline hold.
- done  out  1  one-cycle pulse on HI/LO writeback.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, hi=0, lo=0, done=0. Internal accumulators are cleared. stall=0 while rst_n=0.
- States are IDLE, CALC and FIX.
- IDLE:
  - start=1 latches op, a and b, then goes to CALC with counter=0.
  - Signed ops (op[0]=0) latch |a| and |b| as unsigned values.
  - They also record the result signs. For MULT, sign_p=a[31]^b[31]. For DIV, sign_q=a[31]^b[31] and sign_r=a[31].
- CALC, multiply: 64-bit shift-add, one multiplier bit per cycle, 32 cycles.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle, 32 cycles.
- CALC exit: after counter reaches 31, go to FIX.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Multiply: {hi,lo} = corrected 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Pulse done=1, then return to IDLE.
- Latency: start accepted in cycle 0; CALC occupies cycles 1-32; FIX is cycle 33. New hi/lo are visible from cycle 34.
- stall = (state==IDLE & start & ~flush) | (state!=IDLE). stall is combinational and is low again in cycle 34.
- Divide-by-zero (b==0, DIV or DIVU): still takes the full 34 cycles. Result is lo=DIV0_Q, hi=a as originally presented (raw, not the absolute value). No trap.
- DIV 0x8000_0000 / -1: lo=0x8000_0000, hi=0, with no special case; natural wrap.
- Flush:
  - In CALC or FIX, return to IDLE next cycle with no HI/LO write and no done pulse. Flush has priority over FIX writeback.
  - In IDLE, flush masks start.
- Start while state!=IDLE is ignored.
- MTHI/MTLO:
  - Honoured only in IDLE; ignored while busy.
  - Same cycle as an accepted start: the write happens, and FIX later overwrites both registers.
  - mthi_we and mtlo_we together: both write wdata.
- hi and lo are registered outputs and change only on reset, MTHI/MTLO, or FIX.
- Reset mid-operation aborts immediately to the reset values.

Decomposition:
- Shared package/defines header holds the op encodings (MULT_OP, MULTU_OP, DIV_OP, DIVU_OP) and the state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2).
- One natural sub-module, muldiv_iter_core: holds the combinational one-step shift-add/shift-subtract datapath.
- The FSM, counter, sign handling, and HI/LO registers stay in the top.

Test Plan:
- Reset, then MULT a=-3 (FFFF_FFFD), b=5. Required: stall high for cycles 0-33, done in cycle 33, hi=FFFF_FFFF, lo=FFFF_FFF1 in cycle 34.
- MULTU a=FFFF_FFFF, b=FFFF_FFFF -> hi=FFFF_FFFE, lo=0000_0001. Also DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=-7, b=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF. Also DIV a=8000_0000, b=FFFF_FFFF -> lo=8000_0000, hi=0.
- DIVU a=1234, b=0 -> lo=FFFF_FFFF, hi=1234. Also DIV a=-5, b=0 -> lo=FFFF_FFFF, hi=FFFF_FFFB.
- Preload hi=AAAA_AAAA via MTHI, start MULT, assert flush at cycle 10. Required: IDLE next cycle, stall low, no done, hi unchanged. Repeat with flush in the FIX cycle: same result.
- Assert mtlo_we while busy: lo unchanged. Assert start while busy: ignored. Pulse rst_n low mid-CALC: hi=lo=0, stall=0 immediately.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes and FSM states.
package hilo_muldiv_ctrl_pkg;

    localparam logic [1:0] MULT_OP  = 2'b00;
    localparam logic [1:0] MULTU_OP = 2'b01;
    localparam logic [1:0] DIV_OP   = 2'b10;
    localparam logic [1:0] DIVU_OP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the sequencer datapath: shift-add multiply or restoring shift-subtract divide.
// Purely combinational; the caller registers acc_hi/acc_lo every CALC cycle.
module muldiv_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              is_div,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic [DATA_W-1:0] opnd,
    output logic [DATA_W-1:0] nxt_hi,
    output logic [DATA_W-1:0] nxt_lo
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] sh;
    logic            ge;

    always_comb begin
        sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        sh  = {acc_hi, acc_lo[DATA_W-1]};
        ge  = (sh >= {1'b0, opnd});
        if (is_div) begin
            // remainder lives in acc_hi, dividend shifts out of acc_lo as quotient bits shift in
            nxt_hi = ge ? (sh[DATA_W-1:0] - opnd) : sh[DATA_W-1:0];
            nxt_lo = {acc_lo[DATA_W-2:0], ge};
        end else begin
            {nxt_hi, nxt_lo} = {sum, acc_lo[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner with a 34-cycle iterative MULT/MULTU/DIV/DIVU sequencer and MTHI/MTLO writes.
// Stalls the pipeline from the accepting cycle through FIX; flush aborts without writeback.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                CNT_W  = 6,
    parameter logic [DATA_W-1:0] DIV0_Q = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                div_q, sign_res, sign_r, b_zero;
    logic [DATA_W-1:0]   a_raw, opnd, acc_hi, acc_lo;
    logic [DATA_W-1:0]   step_hi, step_lo;
    logic                accept, wb, is_signed;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   q_fix, r_fix;

    assign accept    = (state == IDLE) && start && !flush;
    assign is_signed = !op[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = (state != IDLE);
        done      = 1'b0;
        wb        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (flush)                             state_nxt = IDLE;
                else if (cnt == CNT_W'(DATA_W - 1))    state_nxt = FIX;
            end
            FIX: begin
                state_nxt = IDLE;
                if (!flush) begin
                    done = 1'b1;
                    wb   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
        .is_div (div_q),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Multiplication is commutative, so |a| always seeds acc_lo and |b| is always the operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_q    <= 1'b0;
            sign_res <= 1'b0;
            sign_r   <= 1'b0;
            b_zero   <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (accept) begin
            cnt      <= '0;
            div_q    <= op[1];
            sign_res <= is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
            sign_r   <= is_signed && a[DATA_W-1];
            b_zero   <= (b == '0);
            a_raw    <= a;
            opnd     <= (is_signed && b[DATA_W-1]) ? -b : b;
            acc_hi   <= '0;
            acc_lo   <= (is_signed && a[DATA_W-1]) ? -a : a;
        end else if (state == CALC) begin
            cnt      <= cnt + CNT_W'(1);
            acc_hi   <= step_hi;
            acc_lo   <= step_lo;
        end
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = sign_res ? -prod : prod;
        q_fix    = sign_res ? -acc_lo : acc_lo;
        r_fix    = sign_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (wb) begin
            if (!div_q) begin
                {hi, lo} <= prod_fix;
            end else if (b_zero) begin
                hi <= a_raw;
                lo <= DIV0_Q;
            end else begin
                hi <= r_fix;
                lo <= q_fix;
            end
        end else if (state == IDLE) begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
        end
    end

endmodule
